if_fetch: RTL and testbench

//  Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID register.

---
 rtl/if_fetch.sv | 136 +++++++++++++
 tb/tb_if_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and assembles each 32-bit instruction from four
// little-endian bytes delivered by the byte-wide memory controller, then hands it to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_interception,
    input  logic [31:0] branch_target,
    input  logic        ifid_stall,
    input  logic        mem_if_valid,
    input  logic [7:0]  mem_if_byte,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] buf_reg;
    logic        req_reg, req_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] pc_out_reg, pc_out_next;
    logic [31:0] inst_reg, inst_next;

    logic        byte_take;
    logic [3:0]  lane_we;

    // A byte only counts while a request is outstanding; stray controller bytes are ignored.
    assign byte_take = (state_reg == FETCH) && req_reg && mem_if_valid && !branch_interception;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign lane_we[gi] = byte_take && (cnt_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || branch_interception) begin
            buf_reg <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    buf_reg[8*i +: 8] <= mem_if_byte;
                end
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        cnt_next    = cnt_reg;
        req_next    = req_reg;
        addr_next   = addr_reg;
        pc_out_next = pc_out_reg;
        inst_next   = inst_reg;

        case (state_reg)
            IDLE: begin
                req_next   = 1'b1;
                addr_next  = pc_reg;
                cnt_next   = 2'd0;
                state_next = FETCH;
            end
            FETCH: begin
                if (byte_take) begin
                    if (cnt_reg != 2'd3) begin
                        cnt_next  = cnt_reg + 2'd1;
                        addr_next = pc_reg + 32'(cnt_reg) + 32'd1;
                    end else begin
                        req_next    = 1'b0;
                        inst_next   = {mem_if_byte, buf_reg[23:0]};
                        pc_out_next = pc_reg;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                // The first unstalled edge is the one IF/ID latches on, so retire here.
                if (!ifid_stall) begin
                    inst_next  = 32'h0;
                    pc_next    = pc_reg + 32'd4;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Redirect beats everything except reset, including a simultaneous IF/ID latch.
        if (branch_interception) begin
            pc_next     = {branch_target[31:2], 2'b00};
            inst_next   = 32'h0;
            pc_out_next = 32'h0;
            req_next    = 1'b0;
            cnt_next    = 2'd0;
            state_next  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            pc_reg     <= {RESET_PC[31:2], 2'b00};
            cnt_reg    <= 2'd0;
            req_reg    <= 1'b0;
            addr_reg   <= 32'h0;
            pc_out_reg <= 32'h0;
            inst_reg   <= 32'h0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            cnt_reg    <= cnt_next;
            req_reg    <= req_next;
            addr_reg   <= addr_next;
            pc_out_reg <= pc_out_next;
            inst_reg   <= inst_next;
        end
    end

    assign if_mem_req  = req_reg;
    assign if_mem_addr = addr_reg;
    assign if_pc       = pc_out_reg;
    assign if_inst     = inst_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: hand-computed expectations checked with immediate assertions.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_interception;
    logic [31:0] branch_target;
    logic        ifid_stall;
    logic        mem_if_valid;
    logic [7:0]  mem_if_byte;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int vectors = 0;
    int miscompares = 0;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch_interception (branch_interception),
        .branch_target       (branch_target),
        .ifid_stall          (ifid_stall),
        .mem_if_valid        (mem_if_valid),
        .mem_if_byte         (mem_if_byte),
        .if_mem_req          (if_mem_req),
        .if_mem_addr         (if_mem_addr),
        .if_pc               (if_pc),
        .if_inst             (if_inst)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        branch_interception = 1'b0;
        branch_target = 32'h0;
        ifid_stall = 1'b0;
        mem_if_valid = 1'b0;
        mem_if_byte = 8'h00;
        step();
        step();
        chk("rst_req", 32'(if_mem_req), 32'd0);
        chk("rst_addr", if_mem_addr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);

        // 1: back-to-back bytes, no stall
        rst = 1'b0;
        step();
        chk("t1_req", 32'(if_mem_req), 32'd1);
        chk("t1_addr0", if_mem_addr, 32'h0);
        mem_if_valid = 1'b1; mem_if_byte = 8'h13;
        step(); chk("t1_addr1", if_mem_addr, 32'h1);
        mem_if_byte = 8'h00;
        step(); chk("t1_addr2", if_mem_addr, 32'h2);
        step(); chk("t1_addr3", if_mem_addr, 32'h3);
        step();
        chk("t1_inst", if_inst, 32'h00000013);
        chk("t1_pc", if_pc, 32'h0);
        chk("t1_req_drop", 32'(if_mem_req), 32'd0);
        mem_if_valid = 1'b0;
        step(); chk("t1_consumed", if_inst, 32'h0);
        step();
        chk("t1_next_req", 32'(if_mem_req), 32'd1);
        chk("t1_next_addr", if_mem_addr, 32'h4);

        // 2: stall 5 cycles in DONE on instruction at pc 4
        mem_if_valid = 1'b1;
        mem_if_byte = 8'h93; step();
        mem_if_byte = 8'h00; step();
        mem_if_byte = 8'h10; step();
        mem_if_byte = 8'h00; ifid_stall = 1'b1; step();
        chk("t2_inst", if_inst, 32'h00100093);
        mem_if_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t2_hold_inst%0d", i), if_inst, 32'h00100093);
            chk($sformatf("t2_hold_pc%0d", i), if_pc, 32'h4);
            chk($sformatf("t2_hold_req%0d", i), 32'(if_mem_req), 32'd0);
        end
        ifid_stall = 1'b0;
        step(); chk("t2_release_inst", if_inst, 32'h0);
        step(); chk("t2_next_addr", if_mem_addr, 32'h8);

        // 3: gapped bytes on cycles 1,3,6,7 at pc 8
        mem_if_valid = 1'b1; mem_if_byte = 8'h23; step();
        chk("t3_addr_c1", if_mem_addr, 32'h9);
        mem_if_valid = 1'b0; mem_if_byte = 8'hee; step();
        chk("t3_addr_c2", if_mem_addr, 32'h9);
        mem_if_valid = 1'b1; mem_if_byte = 8'ha0; step();
        chk("t3_addr_c3", if_mem_addr, 32'hA);
        mem_if_valid = 1'b0; mem_if_byte = 8'hff; step(); step();
        chk("t3_addr_c5", if_mem_addr, 32'hA);
        chk("t3_inst_gap", if_inst, 32'h0);
        mem_if_valid = 1'b1; mem_if_byte = 8'h40; step();
        chk("t3_addr_c6", if_mem_addr, 32'hB);
        mem_if_byte = 8'h00; step();
        chk("t3_inst", if_inst, 32'h0040a023);
        chk("t3_pc", if_pc, 32'h8);
        mem_if_valid = 1'b0;
        step(); step();
        chk("t3_next_addr", if_mem_addr, 32'hC);

        // 4: redirect after 2 bytes, same-cycle byte discarded
        mem_if_valid = 1'b1;
        mem_if_byte = 8'h11; step();
        mem_if_byte = 8'h22; step();
        chk("t4_addr_pre", if_mem_addr, 32'hE);
        branch_interception = 1'b1; branch_target = 32'h00001006; mem_if_byte = 8'h33;
        step();
        chk("t4_req_drop", 32'(if_mem_req), 32'd0);
        chk("t4_inst_flush", if_inst, 32'h0);
        branch_interception = 1'b0; mem_if_valid = 1'b0;
        step();
        chk("t4_new_addr", if_mem_addr, 32'h00001004);
        chk("t4_new_req", 32'(if_mem_req), 32'd1);
        chk("t4_inst_still0", if_inst, 32'h0);
        mem_if_valid = 1'b1;
        mem_if_byte = 8'h13; step();
        mem_if_byte = 8'h05; step();
        mem_if_byte = 8'h10; step();
        mem_if_byte = 8'h00; step();
        chk("t4_inst", if_inst, 32'h00100513);
        chk("t4_pc", if_pc, 32'h00001004);
        mem_if_valid = 1'b0;

        // 5: redirect in DONE together with ifid_stall = 0
        branch_interception = 1'b1; branch_target = 32'h00002000; ifid_stall = 1'b0;
        step();
        chk("t5_inst_drop", if_inst, 32'h0);
        chk("t5_pc_clear", if_pc, 32'h0);
        branch_interception = 1'b0;
        step();
        chk("t5_addr_target", if_mem_addr, 32'h00002000);

        // 6: reset mid-FETCH with a byte arriving
        mem_if_valid = 1'b1;
        mem_if_byte = 8'hAA; step();
        mem_if_byte = 8'hBB; step();
        rst = 1'b1; mem_if_byte = 8'hCC; step();
        chk("t6_req", 32'(if_mem_req), 32'd0);
        chk("t6_addr", if_mem_addr, 32'h0);
        chk("t6_pc", if_pc, 32'h0);
        chk("t6_inst", if_inst, 32'h0);
        rst = 1'b0; mem_if_valid = 1'b0;
        step();
        chk("t6_restart_addr", if_mem_addr, 32'h0);
        chk("t6_restart_req", 32'(if_mem_req), 32'd1);

        // 7: unaligned redirect to top of memory, stray byte in DONE, pc wrap
        branch_interception = 1'b1; branch_target = 32'hFFFFFFFF; step();
        branch_interception = 1'b0; step();
        chk("t7_addr_top", if_mem_addr, 32'hFFFFFFFC);
        mem_if_valid = 1'b1;
        mem_if_byte = 8'h01; step();
        mem_if_byte = 8'h02; step();
        mem_if_byte = 8'h03; step();
        chk("t7_addr_last", if_mem_addr, 32'hFFFFFFFF);
        mem_if_byte = 8'h04; ifid_stall = 1'b1; step();
        chk("t7_inst", if_inst, 32'h04030201);
        chk("t7_pc", if_pc, 32'hFFFFFFFC);
        mem_if_byte = 8'h5A; step();
        chk("t7_stray_ignored", if_inst, 32'h04030201);
        mem_if_valid = 1'b0; ifid_stall = 1'b0; step();
        chk("t7_consumed", if_inst, 32'h0);
        step();
        chk("t7_wrap_addr", if_mem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
